// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the downstream mem_* handshake of mem_arbiter.
// slave is the arbiter's view; master is the caches plus memory side.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  p0_read_enable;
    logic [ADDR_WIDTH-1:0] p0_address;
    logic [DATA_WIDTH-1:0] p0_read_data;
    logic                  p0_read_valid;
    logic                  p0_busy;

    logic                  p1_read_enable;
    logic                  p1_write_enable;
    logic [ADDR_WIDTH-1:0] p1_address;
    logic [DATA_WIDTH-1:0] p1_write_data;
    logic                  p1_store_byte;
    logic                  p1_load_byte;
    logic [DATA_WIDTH-1:0] p1_read_data;
    logic                  p1_read_valid;
    logic                  p1_write_valid;
    logic                  p1_busy;

    logic                  mem_read_enable;
    logic                  mem_write_enable;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic                  mem_store_byte;
    logic                  mem_load_byte;
    logic [DATA_WIDTH-1:0] mem_read_data;
    logic                  mem_read_valid;
    logic                  mem_write_valid;

    modport slave (
        input  p0_read_enable, p0_address,
        output p0_read_data, p0_read_valid, p0_busy,
        input  p1_read_enable, p1_write_enable, p1_address, p1_write_data,
        input  p1_store_byte, p1_load_byte,
        output p1_read_data, p1_read_valid, p1_write_valid, p1_busy,
        output mem_read_enable, mem_write_enable, mem_address, mem_write_data,
        output mem_store_byte, mem_load_byte,
        input  mem_read_data, mem_read_valid, mem_write_valid
    );

    modport master (
        output p0_read_enable, p0_address,
        input  p0_read_data, p0_read_valid, p0_busy,
        output p1_read_enable, p1_write_enable, p1_address, p1_write_data,
        output p1_store_byte, p1_load_byte,
        input  p1_read_data, p1_read_valid, p1_write_valid, p1_busy,
        input  mem_read_enable, mem_write_enable, mem_address, mem_write_data,
        input  mem_store_byte, mem_load_byte,
        output mem_read_data, mem_read_valid, mem_write_valid
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one memory port between instruction fetch (p0) and data (p1).
// MEM_ARB_FIXED_PRIO_EN: p1 always wins a tie instead of round-robin.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    mem_arbiter_if.slave   bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  gnt_port_q, gnt_port_d;
    logic                  gnt_write_q, gnt_write_d;
    logic                  pick_c;

    logic                  p0_busy_q, p0_busy_d;
    logic [ADDR_WIDTH-1:0] p0_addr_q, p0_addr_d;
    logic                  p1_busy_q, p1_busy_d;
    logic                  p1_write_q, p1_write_d;
    logic [ADDR_WIDTH-1:0] p1_addr_q, p1_addr_d;
    logic [DATA_WIDTH-1:0] p1_data_q, p1_data_d;
    logic                  p1_sb_q, p1_sb_d;
    logic                  p1_lb_q, p1_lb_d;

    logic                  mem_read_enable_q, mem_read_enable_d;
    logic                  mem_write_enable_q, mem_write_enable_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0] mem_write_data_q, mem_write_data_d;
    logic                  mem_store_byte_q, mem_store_byte_d;
    logic                  mem_load_byte_q, mem_load_byte_d;

    logic [DATA_WIDTH-1:0] p0_read_data_q, p0_read_data_d;
    logic                  p0_read_valid_q, p0_read_valid_d;
    logic [DATA_WIDTH-1:0] p1_read_data_q, p1_read_data_d;
    logic                  p1_read_valid_q, p1_read_valid_d;
    logic                  p1_write_valid_q, p1_write_valid_d;

    // Request latches, grant, issue and response routing.
    always_comb begin
        state_d            = state_q;
        last_grant_d       = last_grant_q;
        gnt_port_d         = gnt_port_q;
        gnt_write_d        = gnt_write_q;
        p0_busy_d          = p0_busy_q;
        p0_addr_d          = p0_addr_q;
        p1_busy_d          = p1_busy_q;
        p1_write_d         = p1_write_q;
        p1_addr_d          = p1_addr_q;
        p1_data_d          = p1_data_q;
        p1_sb_d            = p1_sb_q;
        p1_lb_d            = p1_lb_q;
        mem_read_enable_d  = 1'b0;
        mem_write_enable_d = 1'b0;
        mem_address_d      = mem_address_q;
        mem_write_data_d   = mem_write_data_q;
        mem_store_byte_d   = mem_store_byte_q;
        mem_load_byte_d    = mem_load_byte_q;
        p0_read_data_d     = p0_read_data_q;
        p0_read_valid_d    = 1'b0;
        p1_read_data_d     = p1_read_data_q;
        p1_read_valid_d    = 1'b0;
        p1_write_valid_d   = 1'b0;

`ifdef MEM_ARB_FIXED_PRIO_EN
        pick_c = p1_busy_q;
`else
        pick_c = p1_busy_q && !(p0_busy_q && last_grant_q);
`endif

        if (!p0_busy_q && bus.p0_read_enable) begin
            p0_busy_d = 1'b1;
            p0_addr_d = bus.p0_address;
        end
        // A simultaneous read and write on p1 is taken as a write.
        if (!p1_busy_q && (bus.p1_read_enable || bus.p1_write_enable)) begin
            p1_busy_d  = 1'b1;
            p1_write_d = bus.p1_write_enable;
            p1_addr_d  = bus.p1_address;
            p1_data_d  = bus.p1_write_data;
            p1_sb_d    = bus.p1_store_byte;
            p1_lb_d    = bus.p1_load_byte;
        end

        case (state_q)
            ST_IDLE: begin
                if (p0_busy_q || p1_busy_q) begin
                    gnt_port_d       = pick_c;
                    last_grant_d     = pick_c;
                    gnt_write_d      = pick_c && p1_write_q;
                    mem_address_d    = pick_c ? p1_addr_q : p0_addr_q;
                    mem_write_data_d = pick_c ? p1_data_q : '0;
                    mem_store_byte_d = pick_c && p1_sb_q;
                    mem_load_byte_d  = pick_c && p1_lb_q;
                    state_d          = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_read_enable_d  = !gnt_write_q;
                mem_write_enable_d = gnt_write_q;
                state_d            = ST_WAIT;
            end
            ST_WAIT: begin
                if (gnt_write_q ? bus.mem_write_valid : bus.mem_read_valid) begin
                    if (gnt_port_q) begin
                        p1_busy_d = 1'b0;
                        if (gnt_write_q) begin
                            p1_write_valid_d = 1'b1;
                        end else begin
                            p1_read_valid_d = 1'b1;
                            p1_read_data_d  = bus.mem_read_data;
                        end
                    end else begin
                        p0_busy_d       = 1'b0;
                        p0_read_valid_d = 1'b1;
                        p0_read_data_d  = bus.mem_read_data;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q            <= ST_IDLE;
            last_grant_q       <= 1'b1;
            gnt_port_q         <= 1'b0;
            gnt_write_q        <= 1'b0;
            p0_busy_q          <= 1'b0;
            p0_addr_q          <= '0;
            p1_busy_q          <= 1'b0;
            p1_write_q         <= 1'b0;
            p1_addr_q          <= '0;
            p1_data_q          <= '0;
            p1_sb_q            <= 1'b0;
            p1_lb_q            <= 1'b0;
            mem_read_enable_q  <= 1'b0;
            mem_write_enable_q <= 1'b0;
            mem_address_q      <= '0;
            mem_write_data_q   <= '0;
            mem_store_byte_q   <= 1'b0;
            mem_load_byte_q    <= 1'b0;
            p0_read_data_q     <= '0;
            p0_read_valid_q    <= 1'b0;
            p1_read_data_q     <= '0;
            p1_read_valid_q    <= 1'b0;
            p1_write_valid_q   <= 1'b0;
        end else begin
            state_q            <= state_d;
            last_grant_q       <= last_grant_d;
            gnt_port_q         <= gnt_port_d;
            gnt_write_q        <= gnt_write_d;
            p0_busy_q          <= p0_busy_d;
            p0_addr_q          <= p0_addr_d;
            p1_busy_q          <= p1_busy_d;
            p1_write_q         <= p1_write_d;
            p1_addr_q          <= p1_addr_d;
            p1_data_q          <= p1_data_d;
            p1_sb_q            <= p1_sb_d;
            p1_lb_q            <= p1_lb_d;
            mem_read_enable_q  <= mem_read_enable_d;
            mem_write_enable_q <= mem_write_enable_d;
            mem_address_q      <= mem_address_d;
            mem_write_data_q   <= mem_write_data_d;
            mem_store_byte_q   <= mem_store_byte_d;
            mem_load_byte_q    <= mem_load_byte_d;
            p0_read_data_q     <= p0_read_data_d;
            p0_read_valid_q    <= p0_read_valid_d;
            p1_read_data_q     <= p1_read_data_d;
            p1_read_valid_q    <= p1_read_valid_d;
            p1_write_valid_q   <= p1_write_valid_d;
        end
    end

    assign bus.p0_read_data     = p0_read_data_q;
    assign bus.p0_read_valid    = p0_read_valid_q;
    assign bus.p0_busy          = p0_busy_q;
    assign bus.p1_read_data     = p1_read_data_q;
    assign bus.p1_read_valid    = p1_read_valid_q;
    assign bus.p1_write_valid   = p1_write_valid_q;
    assign bus.p1_busy          = p1_busy_q;
    assign bus.mem_read_enable  = mem_read_enable_q;
    assign bus.mem_write_enable = mem_write_enable_q;
    assign bus.mem_address      = mem_address_q;
    assign bus.mem_write_data   = mem_write_data_q;
    assign bus.mem_store_byte   = mem_store_byte_q;
    assign bus.mem_load_byte    = mem_load_byte_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory model with ~4-cycle latency, a per-cycle reference model
// of the arbiter's port/memory behaviour, and directed scenarios with literal expectations.
module tb_mem_arbiter;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int          LAT = 4;
`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Backing memory: responds LAT cycles after seeing an enable; stray_en adds a wrong-kind valid.
    logic [31:0] mem_arr [0:63];
    bit          stray_en = 1'b0;
    initial begin
        int          cnt;
        logic        wr, sb, lb;
        logic [31:0] a, wd, rdata;
        int          lane;
        for (int i = 0; i < 64; i++) mem_arr[i] = 32'hdeadbeef + 32'(i);
        bus.mem_read_valid  = 1'b0;
        bus.mem_write_valid = 1'b0;
        bus.mem_read_data   = '0;
        cnt = 0; wr = 1'b0; sb = 1'b0; lb = 1'b0; a = '0; wd = '0;
        forever begin
            @(posedge clk); #1;
            bus.mem_read_valid  = 1'b0;
            bus.mem_write_valid = 1'b0;
            if (bus.mem_read_enable || bus.mem_write_enable) begin
                cnt = LAT - 1;
                wr  = bus.mem_write_enable;
                a   = bus.mem_address;
                wd  = bus.mem_write_data;
                sb  = bus.mem_store_byte;
                lb  = bus.mem_load_byte;
            end else if (cnt > 0) begin
                cnt--;
                lane = int'(a[1:0]);
                if (cnt == 1 && stray_en) begin
                    if (wr) bus.mem_read_valid = 1'b1;
                    else    bus.mem_write_valid = 1'b1;
                end
                if (cnt == 0) begin
                    if (wr) begin
                        if (sb) mem_arr[a[7:2]][lane*8 +: 8] = wd[7:0];
                        else    mem_arr[a[7:2]] = wd;
                        bus.mem_write_valid = 1'b1;
                    end else begin
                        rdata = mem_arr[a[7:2]];
                        if (lb) rdata = {24'h0, rdata[lane*8 +: 8]};
                        bus.mem_read_data  = rdata;
                        bus.mem_read_valid = 1'b1;
                    end
                end
            end
        end
    end

    int total = 0;
    int bad   = 0;
    int n_mre = 0, n_mwe = 0, n_p0rv = 0, n_p1rv = 0, n_p1wv = 0;
    int done_q [$];

    // Reference model: pending requests per port, one owner, age = edges since its grant.
    bit [1:0]    m_busy;
    logic [31:0] m_addr [0:1];
    bit          m_p1_wr, m_p1_sb, m_p1_lb, m_op_wr;
    logic [31:0] m_p1_data;
    int          m_owner, m_age, m_last;
    logic [31:0] e_p0_rd, e_p1_rd, e_maddr, e_mwdata;
    bit          e_p0_rv, e_p1_rv, e_p1_wv, e_p0_busy, e_p1_busy, e_mre, e_mwe, e_msb, e_mlb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = '0; m_owner = -1; m_age = 0; m_last = 1; m_op_wr = 1'b0;
        m_p1_wr = 1'b0; m_p1_sb = 1'b0; m_p1_lb = 1'b0; m_p1_data = '0;
        m_addr[0] = '0; m_addr[1] = '0;
        e_p0_rd = '0; e_p1_rd = '0; e_maddr = '0; e_mwdata = '0;
        e_p0_rv = 1'b0; e_p1_rv = 1'b0; e_p1_wv = 1'b0; e_p0_busy = 1'b0; e_p1_busy = 1'b0;
        e_mre = 1'b0; e_mwe = 1'b0; e_msb = 1'b0; e_mlb = 1'b0;
    endtask

    task automatic model_advance();
        bit cap0, cap1, resp;
        int p;
        if (!reset_n) begin
            model_reset();
            return;
        end
        e_p0_rv = 1'b0; e_p1_rv = 1'b0; e_p1_wv = 1'b0; e_mre = 1'b0; e_mwe = 1'b0;
        cap0 = !m_busy[0] && bus.p0_read_enable;
        cap1 = !m_busy[1] && (bus.p1_read_enable || bus.p1_write_enable);
        resp = 1'b0;
        if (m_owner >= 0 && m_age >= 2)
            resp = m_op_wr ? bus.mem_write_valid : bus.mem_read_valid;
        if (resp) begin
            if (m_owner == 0) begin
                e_p0_rv = 1'b1; e_p0_rd = bus.mem_read_data;
            end else if (m_op_wr) begin
                e_p1_wv = 1'b1;
            end else begin
                e_p1_rv = 1'b1; e_p1_rd = bus.mem_read_data;
            end
            m_busy[m_owner] = 1'b0;
            m_owner = -1;
        end else if (m_owner >= 0) begin
            m_age++;
            if (m_age == 2) begin
                e_mre = !m_op_wr;
                e_mwe = m_op_wr;
            end
        end else if (m_busy != 2'b00) begin
            if (m_busy == 2'b11) p = FIXED ? 1 : 1 - m_last;
            else                 p = m_busy[1] ? 1 : 0;
            m_last   = p;
            m_owner  = p;
            m_age    = 1;
            m_op_wr  = (p == 1) && m_p1_wr;
            e_maddr  = m_addr[p];
            e_mwdata = (p == 1) ? m_p1_data : 32'h0;
            e_msb    = (p == 1) && m_p1_sb;
            e_mlb    = (p == 1) && m_p1_lb;
        end
        if (cap0) begin
            m_busy[0] = 1'b1; m_addr[0] = bus.p0_address;
        end
        if (cap1) begin
            m_busy[1] = 1'b1; m_addr[1] = bus.p1_address; m_p1_wr = bus.p1_write_enable;
            m_p1_data = bus.p1_write_data; m_p1_sb = bus.p1_store_byte; m_p1_lb = bus.p1_load_byte;
        end
        e_p0_busy = m_busy[0];
        e_p1_busy = m_busy[1];
    endtask

    // Runs at every falling edge: compare all outputs, log pulses, step the model.
    task automatic cycle_check();
        if (!reset_n) model_reset();
        chk("p0_read_data",     bus.p0_read_data,             e_p0_rd);
        chk("p0_read_valid",    32'(bus.p0_read_valid),       32'(e_p0_rv));
        chk("p0_busy",          32'(bus.p0_busy),             32'(e_p0_busy));
        chk("p1_read_data",     bus.p1_read_data,             e_p1_rd);
        chk("p1_read_valid",    32'(bus.p1_read_valid),       32'(e_p1_rv));
        chk("p1_write_valid",   32'(bus.p1_write_valid),      32'(e_p1_wv));
        chk("p1_busy",          32'(bus.p1_busy),             32'(e_p1_busy));
        chk("mem_read_enable",  32'(bus.mem_read_enable),     32'(e_mre));
        chk("mem_write_enable", 32'(bus.mem_write_enable),    32'(e_mwe));
        chk("mem_address",      bus.mem_address,              e_maddr);
        chk("mem_write_data",   bus.mem_write_data,           e_mwdata);
        chk("mem_store_byte",   32'(bus.mem_store_byte),      32'(e_msb));
        chk("mem_load_byte",    32'(bus.mem_load_byte),       32'(e_mlb));
        if (bus.mem_read_enable)  n_mre++;
        if (bus.mem_write_enable) n_mwe++;
        if (bus.p0_read_valid) begin n_p0rv++; done_q.push_back(0); end
        if (bus.p1_read_valid) begin n_p1rv++; done_q.push_back(1); end
        if (bus.p1_write_valid) begin n_p1wv++; done_q.push_back(1); end
        model_advance();
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cycle_check();
            @(posedge clk); #1;
        end
    endtask

    task automatic p0_rd(input logic [31:0] a);
        bus.p0_read_enable = 1'b1; bus.p0_address = a;
        step(1);
        bus.p0_read_enable = 1'b0;
    endtask

    task automatic p1_req(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input bit sb, input bit lb);
        bus.p1_read_enable = !wr; bus.p1_write_enable = wr; bus.p1_address = a;
        bus.p1_write_data = d; bus.p1_store_byte = sb; bus.p1_load_byte = lb;
        step(1);
        bus.p1_read_enable = 1'b0; bus.p1_write_enable = 1'b0;
        bus.p1_store_byte = 1'b0; bus.p1_load_byte = 1'b0;
    endtask

    task automatic wait_done();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 100 && !idle; i++) begin
            if (m_busy == 2'b00 && m_owner < 0) idle = 1'b1;
            else step(1);
        end
        chk("wait_timeout", 32'(idle), 32'd1);
        step(2);
    endtask

    initial begin
        int b_re, b_p0, b_p1r, b_p1w, b_q;
        reset_n = 1'b0;
        bus.p0_read_enable = 1'b0; bus.p0_address = '0;
        bus.p1_read_enable = 1'b0; bus.p1_write_enable = 1'b0; bus.p1_address = '0;
        bus.p1_write_data = '0; bus.p1_store_byte = 1'b0; bus.p1_load_byte = 1'b0;
        model_reset();
        step(3);
        chk("lit_reset_p0_busy", 32'(bus.p0_busy), 32'd0);
        chk("lit_reset_mem_addr", bus.mem_address, 32'h0);
        reset_n = 1'b1;
        step(2);

        // Single p0 word read.
        b_re = n_mre; b_p0 = n_p0rv;
        p0_rd(32'h0);
        wait_done();
        chk("lit_p0_rd_en_count", 32'(n_mre - b_re), 32'd1);
        chk("lit_p0_rv_count",    32'(n_p0rv - b_p0), 32'd1);
        chk("lit_p0_data0",       bus.p0_read_data, 32'hdeadbeef);

        // p1 write then read back.
        b_p1w = n_p1wv;
        p1_req(1'b1, 32'h4, 32'h12345678, 1'b0, 1'b0);
        wait_done();
        chk("lit_p1_wv_count", 32'(n_p1wv - b_p1w), 32'd1);
        chk("lit_mem_word1",   mem_arr[1], 32'h12345678);
        p1_req(1'b0, 32'h4, 32'h0, 1'b0, 1'b0);
        wait_done();
        chk("lit_p1_readback", bus.p1_read_data, 32'h12345678);

        // Simultaneous requests right after reset.
        reset_n = 1'b0; step(2); reset_n = 1'b1; step(1);
        b_q = done_q.size();
        bus.p0_read_enable = 1'b1; bus.p0_address = 32'h8;
        p1_req(1'b1, 32'h4, 32'hcafef00d, 1'b0, 1'b0);
        bus.p0_read_enable = 1'b0;
        wait_done();
        chk("lit_tie_completions", 32'(done_q.size() - b_q), 32'd2);
        if (done_q.size() - b_q >= 1)
            chk("lit_tie_first_port", 32'(done_q[b_q]), FIXED ? 32'd1 : 32'd0);
        chk("lit_tie_p0_data", bus.p0_read_data, 32'hdeadbef1);
        chk("lit_tie_word1",   mem_arr[1], 32'hcafef00d);

        // Second p1 pulse while busy is dropped.
        b_re = n_mre; b_p1r = n_p1rv;
        p1_req(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        p1_req(1'b0, 32'h8, 32'h0, 1'b0, 1'b0);
        wait_done();
        chk("lit_drop_rd_en", 32'(n_mre - b_re), 32'd1);
        chk("lit_drop_rv",    32'(n_p1rv - b_p1r), 32'd1);
        chk("lit_drop_data",  bus.p1_read_data, 32'hdeadbeef);

        // Byte store into lane 1, word read, then byte load.
        p1_req(1'b1, 32'h5, 32'h000000aa, 1'b1, 1'b0);
        wait_done();
        p1_req(1'b0, 32'h4, 32'h0, 1'b0, 1'b0);
        wait_done();
        chk("lit_byte_store_word", bus.p1_read_data, 32'hcafeaa0d);
        p1_req(1'b0, 32'h5, 32'h0, 1'b0, 1'b1);
        wait_done();
        chk("lit_byte_load", bus.p1_read_data, 32'h000000aa);

        // Wrong-kind valid during a read wait is ignored.
        stray_en = 1'b1;
        b_p0 = n_p0rv;
        p0_rd(32'hc);
        wait_done();
        stray_en = 1'b0;
        chk("lit_stray_rv",   32'(n_p0rv - b_p0), 32'd1);
        chk("lit_stray_data", bus.p0_read_data, 32'hdeadbef2);

        // p1 latch fills during a p0 transaction and is served next.
        b_q = done_q.size();
        p0_rd(32'h10);
        step(3);
        p1_req(1'b0, 32'h14, 32'h0, 1'b0, 1'b0);
        wait_done();
        chk("lit_queue_p0_data", bus.p0_read_data, 32'hdeadbef3);
        chk("lit_queue_p1_data", bus.p1_read_data, 32'hdeadbef4);
        if (done_q.size() - b_q == 2)
            chk("lit_queue_order", 32'(done_q[b_q + 1]), 32'd1);
        else
            chk("lit_queue_completions", 32'(done_q.size() - b_q), 32'd2);

        // Reset during WAIT; the late response must be ignored.
        b_p0 = n_p0rv;
        p0_rd(32'h18);
        step(3);
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(6);
        chk("lit_abort_rv",   32'(n_p0rv - b_p0), 32'd0);
        chk("lit_abort_data", bus.p0_read_data, 32'h0);
        p0_rd(32'h1c);
        wait_done();
        chk("lit_after_abort_data", bus.p0_read_data, 32'hdeadbef6);
        chk("lit_after_abort_rv",   32'(n_p0rv - b_p0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter that shares the single backing-memory port between the instruction fetch path (port 0, read-only) and the data cache miss/write-through path (port 1, read/write).
- Captures one-cycle request pulses, grants round-robin, issues one memory transaction at a time and routes the response back to the owning requester.
- Sits between the caches and the memory model/controller.
- Its downstream side uses the same mem_* handshake the cache drives today.

Parameters:
ADDR_WIDTH, 32, address width for both requesters and memory
DATA_WIDTH, 32, data width for read/write data

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
p0_read_enable  in  1  port 0 read request pulse (word read)
p0_address  in  ADDR_WIDTH  port 0 address, sampled with request
p0_read_data  out  DATA_WIDTH  port 0 read response data
p0_read_valid  out  1  port 0 read response pulse
p0_busy  out  1  port 0 request latch full; new requests dropped
p1_read_enable  in  1  port 1 read request pulse
p1_write_enable  in  1  port 1 write request pulse
p1_address  in  ADDR_WIDTH  port 1 address
p1_write_data  in  DATA_WIDTH  port 1 write data
p1_store_byte  in  1  byte store (data[7:0] to address[1:0] lane)
p1_load_byte  in  1  byte load (zero-extended by memory)
p1_read_data  out  DATA_WIDTH  port 1 read response data
p1_read_valid  out  1  port 1 read response pulse
p1_write_valid  out  1  port 1 write-complete pulse
p1_busy  out  1  port 1 request latch full
mem_read_enable  out  1  memory read request, one-cycle pulse
mem_write_enable  out  1  memory write request, one-cycle pulse
mem_address  out  ADDR_WIDTH  latched address of granted request
mem_write_data  out  DATA_WIDTH  latched write data
mem_store_byte  out  1  latched store_byte
mem_load_byte  out  1  latched load_byte (0 for port 0)
mem_read_data  in  DATA_WIDTH  memory read data, valid with mem_read_valid
mem_read_valid  in  1  memory read-complete pulse
mem_write_valid  in  1  memory write-complete pulse

Behaviour:
- Reset (async, reset_n low): all outputs 0; request latches empty; FSM IDLE; last_grant=1, so port 0 wins the first tie.
- Request capture: at a rising edge with the latch empty and enable high, latch {op, address, data, byte flags}.
- pN_busy is the latch-full register. Enables seen while busy are dropped silently.
- p1 read and write both high in the same cycle: treated as a write.
- FSM IDLE:
  - If any latch is full, grant at the next edge and go to ISSUE.
  - If both latches are full, grant the port != last_grant. Update last_grant on every grant.
- FSM ISSUE (1 cycle):
  - Drive mem_read_enable or mem_write_enable high for exactly this cycle.
  - mem_address, mem_write_data and the mem byte flags come from the granted latch and stay stable until the response.
  - Go to WAIT.
- FSM WAIT:
  - Hold until the matching mem valid (read→mem_read_valid, write→mem_write_valid). Non-matching valids are ignored.
  - At that edge: the granted port's read_valid/write_valid is registered high for 1 cycle; pN_read_data captures mem_read_data on reads.
  - Clear the granted latch and return to IDLE.
- Latency:
  - Request edge E0 → mem enable high in the cycle after E2 (latch at E0, grant at E1, ISSUE at E2).
  - Response is port-visible 1 cycle after mem valid.
- A request arriving on the response edge is dropped, because busy is still high that cycle.
- The other port's latch may fill during a transaction; it is served on the next IDLE.
- pN_read_data holds its last value between responses. The non-granted port's data is untouched.
- Mem valid pulses in IDLE or ISSUE are ignored.
- Reset mid-transaction: abort immediately. Late memory responses after reset are ignored (FSM is IDLE).

Optional Feature:
- MEM_ARB_FIXED_PRIO_EN defined: port 1 (data) always wins when both latches are full; last_grant is unused.
- Undefined: round-robin as above. All other behaviour is identical.

Test Plan:
- Memory word[i]=32'hdeadbeef+i, ~4-cycle latency. p0 read addr 0 → one p0_read_valid pulse, p0_read_data=deadbeef; mem_read_enable high exactly 1 cycle.
- p1 write addr 4 data 12345678 → p1_write_valid pulse, memory word[1]=12345678. Then p1 read addr 4 → p1_read_data=12345678.
- p0 read addr 8 and p1 write addr 4 in the same cycle after reset → port 0 is served first (p0_read_data=deadbef1), then the p1 write.
  - With MEM_ARB_FIXED_PRIO_EN, the p1 write completes before the p0 read.
- p1 pulses a second read while p1_busy=1 → dropped; exactly one mem_read_enable and one p1_read_valid.
- p1 byte store 8'hAA to addr 5, then word read addr 4 → data[15:8]=AA, other bytes unchanged.
- reset_n low during WAIT, then high → all outputs 0; the late mem_read_valid produces no pN_read_valid; the next request works normally.
